// File: rtl/btn_counter_pkg.sv
// Shared types for the button-driven counter scheduler.
package btn_counter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_INC = 2'b00,
    OP_DEC = 2'b01,
    OP_CLR = 2'b10,
    OP_NOP = 2'b11
  } op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import btn_counter_pkg::*;
#(
  parameter int  N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [PW-1:0] gnt_idx
);

  int j;

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt[j]    = 1'b1;
        gnt_idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/btn_counter_scheduler.sv
// One shared counter driven by per-button release events, served round-robin
// one per clock; each channel applies its own statically configured op.
module btn_counter_scheduler
  import btn_counter_pkg::*;
#(
  parameter int NUM_BTNS    = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_BTNS-1:0]      btn,
  input  logic [OP_W*NUM_BTNS-1:0] op_cfg,
  output logic [COUNT_WIDTH-1:0]   count,
  output logic [NUM_BTNS-1:0]      grant,
  output logic                     wrap,
  output logic                     dropped,
  output logic                     busy
);

  localparam int PW = $clog2(NUM_BTNS);

  logic [NUM_BTNS-1:0]    pressed;
  logic [NUM_BTNS-1:0]    pending;
  logic [NUM_BTNS-1:0]    rel;
  logic [NUM_BTNS-1:0]    arb_gnt;
  logic                   arb_valid;
  logic [PW-1:0]          arb_idx;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          ptr_nxt;
  op_t                    op;
  logic [COUNT_WIDTH-1:0] count_nxt;
  logic                   wrap_nxt;

  assign rel  = pressed & ~btn;
  assign busy = |pending;

  rr_arbiter #(.N(NUM_BTNS)) u_arb (
    .req      (pending),
    .ptr      (rr_ptr),
    .gnt      (arb_gnt),
    .gnt_valid(arb_valid),
    .gnt_idx  (arb_idx)
  );

  // op is looked up at grant time, so a reconfigured channel uses its new op
  always_comb begin
    op = OP_NOP;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (arb_gnt[i]) op = op_t'(op_cfg[OP_W*i +: OP_W]);
    end
  end

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    ptr_nxt   = (arb_idx == PW'(NUM_BTNS - 1)) ? '0 : arb_idx + 1'b1;
    if (arb_valid) begin
      case (op)
        OP_INC: begin
          count_nxt = count + 1'b1;
          wrap_nxt  = &count;
        end
        OP_DEC: begin
          count_nxt = count - 1'b1;
          wrap_nxt  = ~|count;
        end
        OP_CLR:  count_nxt = '0;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pressed <= '0;
      pending <= '0;
      rr_ptr  <= '0;
      count   <= '0;
      grant   <= '0;
      wrap    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      // pressed tracks the level: set on the first high sample, cleared on release
      pressed <= btn;
      // a release on the channel being granted re-arms it instead of dropping
      pending <= (pending & ~arb_gnt) | rel;
      if (|(rel & pending & ~arb_gnt)) dropped <= 1'b1;
      grant   <= arb_gnt;
      count   <= count_nxt;
      wrap    <= wrap_nxt;
      if (arb_valid) rr_ptr <= ptr_nxt;
    end
  end

endmodule
